// File: rtl/key_press_detector_if.sv
// Pixel stream from the camera capture path plus the debounced key outputs returned to the note logic.
// master drives pixels and observes keys; slave is the detector.
interface key_press_detector_if #(
   parameter int NUM_KEYS = 8
);
   logic [10:0]         hcount;
   logic [9:0]          vcount;
   logic [23:0]         pixel;
   logic                pixel_valid;
   logic                frame_end;
   logic [NUM_KEYS-1:0] keys_pressed;
   logic [NUM_KEYS-1:0] press_strobe;
   logic [NUM_KEYS-1:0] release_strobe;
   logic                frame_done;

   modport master (
      output hcount, vcount, pixel, pixel_valid, frame_end,
      input  keys_pressed, press_strobe, release_strobe, frame_done
   );

   modport slave (
      input  hcount, vcount, pixel, pixel_valid, frame_end,
      output keys_pressed, press_strobe, release_strobe, frame_done
   );
endinterface

// File: rtl/key_press_detector.sv
// Counts marker-coloured pixels per white-key rectangle, thresholds them at frame end and debounces across frames.
// Hit counts lag the pixel by one cycle; outputs update on the frame_end edge; the pixel stream is never stalled.
module key_press_detector #(
   parameter int         NUM_KEYS        = 8,
   parameter int         X0              = 64,
   parameter int         Y0              = 128,
   parameter int         WHITE_KEY_WIDTH = 90,
   parameter int         HEIGHT          = 256,
   parameter logic [7:0] R_MIN           = 8'hC0,
   parameter logic [7:0] G_MAX           = 8'h60,
   parameter logic [7:0] B_MAX           = 8'h60,
   parameter int         HIT_THRESHOLD   = 200,
   parameter int         DEBOUNCE_FRAMES = 3
) (
   input logic                 clock,
   input logic                 reset,
   key_press_detector_if.slave bus
);
   localparam logic [11:0] Y_LO      = 12'(Y0);
   localparam logic [11:0] Y_HI      = 12'(Y0 + HEIGHT);
   localparam logic [15:0] THRESH    = 16'(HIT_THRESHOLD);
   localparam logic [3:0]  DEB_LIMIT = 4'(DEBOUNCE_FRAMES);

   logic [11:0]         hx;
   logic [11:0]         vy;
   logic                pix_hit;
   logic                row_hit;
   logic                eval;
   logic [NUM_KEYS-1:0] key_hit;
   logic [NUM_KEYS-1:0] raw;

   logic [15:0]         cnt_q [NUM_KEYS];
   logic [15:0]         cnt_d [NUM_KEYS];
   logic [3:0]          deb_q [NUM_KEYS];
   logic [3:0]          deb_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] keys_q, keys_d;
   logic [NUM_KEYS-1:0] press_q, press_d;
   logic [NUM_KEYS-1:0] rel_q, rel_d;
   logic                done_q, done_d;

   assign hx      = {1'b0, bus.hcount};
   assign vy      = {2'b00, bus.vcount};
   assign pix_hit = bus.pixel_valid && (bus.pixel[23:16] >= R_MIN)
                    && (bus.pixel[15:8] <= G_MAX) && (bus.pixel[7:0] <= B_MAX);
   assign row_hit = (vy >= Y_LO) && (vy < Y_HI);

   // A frame_end directly after an evaluated one is an empty duplicate frame; skipping it keeps pulses one cycle wide.
   assign eval = bus.frame_end && !done_q;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      localparam logic [11:0] XL = 12'(X0 + k * WHITE_KEY_WIDTH);
      localparam logic [11:0] XH = 12'(X0 + (k + 1) * WHITE_KEY_WIDTH);
      assign key_hit[k] = pix_hit && row_hit && (hx >= XL) && (hx < XH);
      assign raw[k]     = (cnt_q[k] >= THRESH);
   end

   always_comb begin
      keys_d  = keys_q;
      press_d = '0;
      rel_d   = '0;
      done_d  = eval;
      for (int k = 0; k < NUM_KEYS; k++) begin
         cnt_d[k] = cnt_q[k];
         deb_d[k] = deb_q[k];
         if (bus.frame_end) begin
            cnt_d[k] = '0;
         end else if (key_hit[k] && (cnt_q[k] != 16'hFFFF)) begin
            cnt_d[k] = cnt_q[k] + 16'd1;
         end
         if (eval) begin
            if (raw[k] == keys_q[k]) begin
               deb_d[k] = '0;
            end else if ((deb_q[k] + 4'd1) == DEB_LIMIT) begin
               deb_d[k]   = '0;
               keys_d[k]  = ~keys_q[k];
               press_d[k] = ~keys_q[k];
               rel_d[k]   = keys_q[k];
            end else begin
               deb_d[k] = deb_q[k] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         keys_q  <= '0;
         press_q <= '0;
         rel_q   <= '0;
         done_q  <= 1'b0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_q[k] <= '0;
            deb_q[k] <= '0;
         end
      end else begin
         keys_q  <= keys_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         done_q  <= done_d;
         for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_q[k] <= cnt_d[k];
            deb_q[k] <= deb_d[k];
         end
      end
   end

   assign bus.keys_pressed   = keys_q;
   assign bus.press_strobe   = press_q;
   assign bus.release_strobe = rel_q;
   assign bus.frame_done     = done_q;
endmodule
